// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the simple_cpu program sequencer: instruction classes,
// the class field position and the sequencer state encoding.
package simple_cpu_pkg;

  localparam int INSTR_WIDTH_DEF = 20;

  localparam int CLS_MSB = 19;
  localparam int CLS_LSB = 18;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_RST = 2'b01,
    RUN     = 2'b10,
    DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/seq_imem.sv
// Instruction memory: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module seq_imem #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

  // write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simple_cpu_sequencer.sv
// Program sequencer for simple_cpu: resets the CPU for one cycle, then presents
// each stored instruction for a class-dependent number of cycles until HALT/end/abort.
module simple_cpu_sequencer
  import simple_cpu_pkg::*;
#(
  parameter int INSTR_WIDTH    = INSTR_WIDTH_DEF,
  parameter int IMEM_ADDR_BITS = 4,
  parameter int ALU_CYCLES     = 3,
  parameter int STORE_CYCLES   = 3,
  parameter int LOAD_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      prog_we,
  input  logic [IMEM_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  output logic                      cpu_rst,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [IMEM_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int MAX_HOLD_AS = (ALU_CYCLES > STORE_CYCLES) ? ALU_CYCLES : STORE_CYCLES;
  localparam int MAX_HOLD    = (LOAD_CYCLES > MAX_HOLD_AS) ? LOAD_CYCLES : MAX_HOLD_AS;
  localparam int CNT_W       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [IMEM_ADDR_BITS-1:0] LAST_ADDR = {IMEM_ADDR_BITS{1'b1}};

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [INSTR_WIDTH-1:0]    r_instr;
  logic [INSTR_WIDTH-1:0]    w_instr_nxt;
  logic [IMEM_ADDR_BITS-1:0] r_pc;
  logic [IMEM_ADDR_BITS-1:0] w_pc_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [IMEM_ADDR_BITS-1:0] w_rd_addr;
  logic [INSTR_WIDTH-1:0]    w_rd_data;
  logic [1:0]                w_rd_cls;
  logic                      w_busy;

  // Remaining cycles after the first one that an instruction of class cls is held.
  function automatic logic [CNT_W-1:0] hold_m1(input logic [1:0] cls);
    case (cls)
      CLS_ALU:   return CNT_W'(ALU_CYCLES - 1);
      CLS_LOAD:  return CNT_W'(LOAD_CYCLES - 1);
      CLS_STORE: return CNT_W'(STORE_CYCLES - 1);
      default:   return CNT_W'(0);
    endcase
  endfunction

  assign w_busy    = (r_state == CPU_RST) || (r_state == RUN);
  // CPU_RST fetches word 0; RUN looks ahead to the next word (wrap is guarded below).
  assign w_rd_addr = (r_state == RUN) ? (r_pc + IMEM_ADDR_BITS'(1)) : {IMEM_ADDR_BITS{1'b0}};
  assign w_rd_cls  = w_rd_data[CLS_MSB:CLS_LSB];

  seq_imem #(
    .ADDR_BITS  (IMEM_ADDR_BITS),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_imem (
    .clk     (clk),
    .i_we    (prog_we && !w_busy),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // state, instruction, pc and hold-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_instr <= {INSTR_WIDTH{1'b0}};
      r_pc    <= {IMEM_ADDR_BITS{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state logic: start, abort and instruction advance
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, DONE: begin
        w_instr_nxt = {INSTR_WIDTH{1'b0}};
        if (start) begin
          w_state_nxt = CPU_RST;
          w_pc_nxt    = {IMEM_ADDR_BITS{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = r_state;
        end
      end
      CPU_RST: begin
        w_instr_nxt = {INSTR_WIDTH{1'b0}};
        w_pc_nxt    = {IMEM_ADDR_BITS{1'b0}};
        if (abort || (w_rd_cls == CLS_HALT)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
          w_instr_nxt = w_rd_data;
          w_cnt_nxt   = hold_m1(w_rd_cls);
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = DONE;
          w_instr_nxt = {INSTR_WIDTH{1'b0}};
        end else if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if ((r_pc == LAST_ADDR) || (w_rd_cls == CLS_HALT)) begin
          w_state_nxt = DONE;
          w_instr_nxt = {INSTR_WIDTH{1'b0}};
        end else begin
          w_instr_nxt = w_rd_data;
          w_pc_nxt    = w_rd_addr;
          w_cnt_nxt   = hold_m1(w_rd_cls);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_instr_nxt = {INSTR_WIDTH{1'b0}};
        w_pc_nxt    = {IMEM_ADDR_BITS{1'b0}};
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign cpu_rst     = rst || (r_state == CPU_RST);
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign busy        = w_busy;
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// Directed self-checking bench for simple_cpu_sequencer.
module tb_simple_cpu_sequencer;

  localparam logic [19:0] I_A = 20'h47000;
  localparam logic [19:0] I_B = 20'h53000;
  localparam logic [19:0] I_C = 20'h72001;
  localparam logic [19:0] I_S = 20'hD80F0;
  localparam logic [19:0] I_L = 20'hB80F0;
  localparam logic [19:0] I_H = 20'h00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [19:0] prog_data = 20'h0;
  logic        cpu_rst;
  logic [19:0] instruction;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc = 0;

  simple_cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .cpu_rst     (cpu_rst),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_c, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_c) begin
      tick();
      n++;
    end
  endtask

  task automatic load_s1();
    load(4'd0, I_A);
    load(4'd1, I_B);
    load(4'd2, I_C);
    load(4'd3, I_H);
  endtask

  // 3 ALU instructions held 3 cycles each, DONE on the 10th edge after start
  task automatic run_s1();
    logic [19:0] e;
    pulse_start();
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s1_busy_rst", 32'(busy), 32'd1);
    chk("s1_instr_rst", 32'(instruction), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      e = (k <= 3) ? I_A : ((k <= 6) ? I_B : I_C);
      chk("s1_instr", 32'(instruction), 32'(e));
      chk("s1_pc", 32'(pc), 32'((k - 1) / 3));
      chk("s1_cpu_rst_run", 32'(cpu_rst), 32'd0);
    end
    tick();
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_instr_done", 32'(instruction), 32'd0);
    chk("s1_pc_done", 32'(pc), 32'd2);
    chk("s1_busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    tick();
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd0);

    // scenario 1
    load_s1();
    run_s1();

    // scenario 2: STORE_R held 3, LOAD_R held 4
    load(4'd0, I_S);
    load(4'd1, I_L);
    load(4'd2, I_H);
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("s2_instr", 32'(instruction), (k < 3) ? 32'(I_S) : 32'(I_L));
    end
    tick();
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_pc", 32'(pc), 32'd1);

    // scenario 3: full memory, no HALT, no pc wrap
    for (int a = 0; a < 16; a++) begin
      load(4'(a), I_A);
    end
    pulse_start();
    for (int k = 0; k < 48; k++) begin
      tick();
      chk("s3_instr", 32'(instruction), 32'(I_A));
      chk("s3_pc", 32'(pc), 32'(k / 3));
    end
    tick();
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_pc_end", 32'(pc), 32'd15);
    chk("s3_instr_end", 32'(instruction), 32'd0);

    // scenario 4: abort in the 2nd cycle of the instruction at pc 1
    load(4'd3, I_H);
    pulse_start();
    repeat (5) tick();
    chk("s4_pc_pre", 32'(pc), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_instr", 32'(instruction), 32'd0);
    chk("s4_pc", 32'(pc), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s4_abort_in_done", 32'(done), 32'd1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("s4_restart_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s4_restart_done", 32'(done), 32'd0);
    chk("s4_restart_pc", 32'(pc), 32'd0);
    tick();
    chk("s4_restart_instr", 32'(instruction), 32'(I_A));
    wait_done(100, n_cyc);
    chk("s4_restart_cycles", 32'(n_cyc), 32'd9);
    chk("s4_restart_pc_end", 32'(pc), 32'd2);

    // scenario 5: write and start while busy are ignored
    pulse_start();
    tick();
    prog_we   = 1'b1;
    prog_addr = 4'd2;
    prog_data = I_H;
    start     = 1'b1;
    tick();
    prog_we   = 1'b0;
    start     = 1'b0;
    wait_done(100, n_cyc);
    chk("s5_busy_cycles", 32'(n_cyc), 32'd8);
    chk("s5_busy_pc", 32'(pc), 32'd2);
    load(4'd2, I_H);
    pulse_start();
    wait_done(100, n_cyc);
    chk("s5_after_cycles", 32'(n_cyc), 32'd7);
    chk("s5_after_pc", 32'(pc), 32'd1);

    // scenario 6: rst mid-RUN keeps memory
    load_s1();
    pulse_start();
    repeat (4) tick();
    chk("s6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("s6_instr", 32'(instruction), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    chk("s6_pc", 32'(pc), 32'd0);
    chk("s6_cpu_rst", 32'(cpu_rst), 32'd1);
    rst = 1'b0;
    #1;
    chk("s6_cpu_rst_rel", 32'(cpu_rst), 32'd0);
    run_s1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simple_cpu_sequencer.md
Name: simple_cpu_sequencer

Overview:
Program sequencer for simple_cpu. It holds a small instruction memory that the bench or host loads while the CPU is idle. After a start pulse it resets the CPU for one cycle, then presents each instruction on the CPU `instruction` input for a class-dependent number of cycles. It stops on a HALT word, at the end of memory, or on an abort, and reports busy/done.

Parameters:
INSTR_WIDTH, 20, instruction width; must match simple_cpu.
IMEM_ADDR_BITS, 4, instruction memory depth is 2**IMEM_ADDR_BITS words (16).
ALU_CYCLES, 3, cycles each ALU instruction (class 2'b01) is held.
STORE_CYCLES, 3, cycles each STORE_R instruction (class 2'b11) is held.
LOAD_CYCLES, 4, cycles each LOAD_R instruction (class 2'b10) is held.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
abort  in  1  stops execution; effective only in CPU_RST or RUN.
prog_we  in  1  instruction-memory write enable; ignored while busy.
prog_addr  in  IMEM_ADDR_BITS  write address.
prog_data  in  INSTR_WIDTH  write data.
cpu_rst  out  1  drives simple_cpu rst.
instruction  out  INSTR_WIDTH  registered instruction to simple_cpu.
pc  out  IMEM_ADDR_BITS  address of the instruction currently presented.
busy  out  1  high in CPU_RST and RUN.
done  out  1  high in DONE.

Behaviour:
- Instruction class is instr[19:18]: 00 = HALT, 01 = ALU, 10 = LOAD_R, 11 = STORE_R. Hold count: ALU -> ALU_CYCLES, LOAD_R -> LOAD_CYCLES, STORE_R -> STORE_CYCLES. All hold counts are at least 1.
- Reset: state = IDLE, instruction = 0, pc = 0, hold counter = 0, cpu_rst = 1, busy = 0, done = 0. Memory contents are not cleared.
- cpu_rst = rst OR (state == CPU_RST). It is combinational from registered state.
- IDLE: instruction = 0. The edge on which start is sampled moves to CPU_RST.
- CPU_RST: lasts exactly one cycle, with instruction = 0 and pc = 0. At the next edge:
  - if imem[0] is HALT, go to DONE;
  - otherwise go to RUN with instruction = imem[0], pc = 0, counter = hold(imem[0]) - 1.
- RUN with counter != 0: decrement the counter; instruction is held.
- RUN with counter == 0: let next = pc + 1.
  - If pc == 2**IMEM_ADDR_BITS - 1 (no wrap) or imem[next] is HALT, go to DONE with instruction = 0.
  - Otherwise load instruction = imem[next], pc = next, counter = hold - 1.
  - Instructions are issued back to back, with no bubble cycle.
- DONE: instruction = 0, done = 1, pc holds the last executed address. A start pulse restarts via CPU_RST and clears done on that edge.
- Abort in CPU_RST or RUN: go to DONE on the next edge with instruction = 0. Abort has priority over normal advance. Abort in IDLE or DONE is ignored.
- Start while busy is ignored. If start and abort are asserted together in IDLE or DONE, start wins.
- Memory writes are combinational-read, synchronous-write. The write happens only when !busy. A write on the same edge a start is accepted takes effect, and CPU_RST reads the new value.
- rst asserted mid-RUN forces the reset values on that edge. The program in memory is kept.

Decomposition:
- Shared package simple_cpu_pkg holds:
  - the class encodings (CLS_HALT = 2'b00, CLS_ALU = 2'b01, CLS_LOAD = 2'b10, CLS_STORE = 2'b11);
  - the class field position (19:18);
  - the state enum (IDLE, CPU_RST, RUN, DONE);
  - a default INSTR_WIDTH of 20.
- One sub-module, seq_imem: the parameterised register-array instruction memory with one write port and one combinational read port.
- The FSM and hold counter stay in the top module.

Test Plan:
1. Load imem[0..3] = 20'h47000, 20'h53000, 20'h72001, 20'h00000, then pulse start at edge E0.
   - cpu_rst = 1 for the cycle after E0.
   - instruction = 47000 over E1–E3, 53000 over E4–E6, 72001 over E7–E9.
   - At E10: DONE, instruction = 0, done = 1, pc = 2.
   - The CPU regfile ends at reg0 = 4, reg1 = 7, reg3 = 2.
2. Load 20'hD80F0 (STORE_R), 20'hB80F0 (LOAD_R), then HALT.
   - Store is held for 3 cycles, load for 4 cycles.
   - done rises 7 cycles after CPU_RST; the CPU reg3 reads 7.
3. Fill all 16 words with 20'h47000 (no HALT) and start.
   - 48 RUN cycles, then DONE with pc = 15.
   - pc never wraps to 0.
4. Start a 3-ALU program and assert abort in the 2nd cycle of instruction 1.
   - Next edge: DONE, instruction = 0, pc = 1.
   - A subsequent start re-runs from pc = 0 via CPU_RST.
5. During RUN, pulse prog_we to addr 2 with data 20'h00000, and pulse start.
   - Both are ignored: the program runs unchanged.
   - After DONE, the same write succeeds and a restart halts after 2 instructions.
6. Assert rst for one cycle mid-RUN.
   - Next cycle: IDLE, instruction = 0, busy = 0, done = 0, cpu_rst = 1 during rst.
   - The memory retains its program and a restart reproduces the scenario 1 timing.
